child_dispatch_rr: RTL

//   Work-token dispatcher sitting directly upstream of a hierarchy node's child

---
 rtl/child_dispatch_rr.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/child_dispatch_rr.sv
// child_dispatch_rr
//   Work-token dispatcher placed upstream of a node's child instances. Incoming
//   tokens are buffered in a small FIFO. Each token goes to exactly one child
//   over a per-child valid/ready handshake. A token is either directed (it names
//   a child index) or "any" (the child is picked round-robin). An "any" token
//   that stalls on one child is moved to the next child after TIMEOUT cycles.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           synchronous reset, active low
//   in_valid_i       upstream token valid
//   in_ready_o       FIFO can accept (not full, and low during reset)
//   in_data_i        token payload
//   in_dest_i        child index, or all-ones for "any"
//   out_valid_o      one-hot (or zero) offer to each child
//   out_ready_i      per-child accept
//   out_data_o       registered payload shared by all children
//   err_drop_o       one-cycle pulse when a directed token with a bad index is dropped
//   dispatch_cnt_o   count of completed dispatches, wraps at 16 bits
module child_dispatch_rr #(
    parameter int unsigned N_CHILD    = 15,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEST_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [DEST_W-1:0]   in_dest_i,
    output logic [N_CHILD-1:0]  out_valid_o,
    input  logic [N_CHILD-1:0]  out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic                err_drop_o,
    output logic [15:0]         dispatch_cnt_o
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned TW   = $clog2(N_CHILD);
    localparam int unsigned CW   = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        RETARGET
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic [DEST_W-1:0]   mem_dest_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]     count_q;
    logic [TW-1:0]       target_q, target_d;
    logic [TW-1:0]       rr_q, rr_d;
    logic                any_q, any_d;
    logic [CW-1:0]       timer_q, timer_d;
    logic [N_CHILD-1:0]  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                full, empty, push, pop, load;
    logic [DATA_W-1:0]   head_data;
    logic [DEST_W-1:0]   head_dest;
    logic                head_any, head_ok;

    function automatic logic [TW-1:0] next_child(input logic [TW-1:0] t);
        if (32'(t) == N_CHILD - 1) return '0;
        return t + 1'b1;
    endfunction

    assign full       = (count_q == CNTW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    // No push-through: a full FIFO refuses even when a pop happens this cycle.
    assign in_ready_o = rst_ni && !full;
    assign push       = in_valid_i && in_ready_o;

    assign head_data  = mem_data_q[rd_ptr_q];
    assign head_dest  = mem_dest_q[rd_ptr_q];
    assign head_any   = &head_dest;
    assign head_ok    = (32'(head_dest) < N_CHILD);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        any_d       = any_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                load = !empty;
            end
            OFFER: begin
                if (out_ready_i[target_q]) begin
                    cnt_d       = cnt_q + 16'd1;
                    if (any_q) rr_d = next_child(target_q);
                    out_valid_d = '0;
                    state_d     = IDLE;
                    load        = !empty;
                end else if (any_q) begin
                    if (timer_q == CW'(TIMEOUT - 1)) begin
                        out_valid_d = '0;
                        state_d     = RETARGET;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            RETARGET: begin
                target_d              = next_child(target_q);
                out_valid_d           = '0;
                out_valid_d[target_d] = 1'b1;
                state_d               = OFFER;
                timer_d               = '0;
            end
            default: state_d = IDLE;
        endcase

        // Head load shared by IDLE and the back-to-back path after a transfer;
        // an "any" head uses the round-robin pointer already advanced above.
        if (load) begin
            if (head_any || head_ok) begin
                target_d              = head_any ? rr_d : TW'(head_dest);
                any_d                 = head_any;
                out_valid_d           = '0;
                out_valid_d[target_d] = 1'b1;
                out_data_d            = head_data;
                timer_d               = '0;
                state_d               = OFFER;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    assign pop = load;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data_i;
            mem_dest_q[wr_ptr_q] <= in_dest_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            target_q    <= '0;
            any_q       <= 1'b0;
            rr_q        <= '0;
            timer_q     <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            any_q       <= any_d;
            rr_q        <= rr_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign err_drop_o     = err_q;
    assign dispatch_cnt_o = cnt_q;

endmodule
